// File: rtl/reg_slice_pkg.sv
// Shared types and helpers for the multi-channel register slice.
// Holds the occupancy-encoded state type and channel slicing arithmetic.
package reg_slice_pkg;

  // State encoding doubles as the occupancy level.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int LEVEL_W = 2;

  // Low bit index of channel k in a packed word of w-bit channels.
  function automatic int chan_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_slice_skid_core.sv
// Width-generic 2-entry skid buffer with registered ready and a
// completed-transfer counter.
module reg_slice_skid_core
  import reg_slice_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   xfer_cnt
);

  state_t           state_reg, state_next;
  logic [DW-1:0]    main_reg, main_next;
  logic [DW-1:0]    skid_reg, skid_next;
  logic             in_ready_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          state_next = BUSY;
          main_next  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (in_fire) begin
          state_next = FULL;
          skid_next  = in_data;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the consumer can make progress.
        if (out_fire) begin
          state_next = BUSY;
          main_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != FULL);
      if (out_fire) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign level     = LEVEL_W'(state_reg);
  assign xfer_cnt  = cnt_reg;

endmodule

// File: rtl/multi_channel_reg_slice.sv
// Multi-channel register slice: per-channel capture mask merged against the
// last accepted word, then buffered through a 2-entry skid core.
module multi_channel_reg_slice
  import reg_slice_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_chan_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [LEVEL_W-1:0]      level,
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic [NUM_CH*WIDTH-1:0] last_reg;
  logic [NUM_CH*WIDTH-1:0] merged;
  logic                    in_fire;

  assign in_fire = in_valid & in_ready;

  // Masked-off channels repeat their previous value; last only moves on accept.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign merged[chan_lo(gi, WIDTH) +: WIDTH] =
        in_chan_en[gi] ? in_data[chan_lo(gi, WIDTH) +: WIDTH]
                       : last_reg[chan_lo(gi, WIDTH) +: WIDTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          last_reg[chan_lo(gi, WIDTH) +: WIDTH] <= '0;
        end else if (in_fire) begin
          last_reg[chan_lo(gi, WIDTH) +: WIDTH] <= merged[chan_lo(gi, WIDTH) +: WIDTH];
        end
      end
    end
  endgenerate

  reg_slice_skid_core #(
    .DW    (NUM_CH * WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (merged),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .xfer_cnt  (xfer_cnt)
  );

endmodule

// File: tb/tb_multi_channel_reg_slice.sv
// Directed bench for multi_channel_reg_slice with a merge-model scoreboard
// that predicts each output word from accepted inputs.
module tb_multi_channel_reg_slice;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int DW     = NUM_CH * WIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic [NUM_CH-1:0] in_chan_en = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic [1:0]        level;
  logic [CNT_W-1:0]  xfer_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] last_m = '0;
  logic [DW-1:0] w_m;

  multi_channel_reg_slice #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_chan_en (in_chan_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Inputs change 1 time unit after posedge, so at negedge they show exactly
  // what the next posedge will see.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last_m = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {16'h0, out_data}, 32'hDEAD);
        end else begin
          check("out_word", {16'h0, out_data}, {16'h0, sb.pop_front()});
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < NUM_CH; k++) begin
          w_m[k*WIDTH +: WIDTH] = in_chan_en[k] ? in_data[k*WIDTH +: WIDTH]
                                                : last_m[k*WIDTH +: WIDTH];
        end
        last_m = w_m;
        sb.push_back(w_m);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NUM_CH-1:0] m);
    in_valid   = v;
    in_data    = d;
    in_chan_en = m;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset and idle
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_out_data", out_data, 0);
    check("rst_xfer_cnt", xfer_cnt, 0);

    // Streaming, one word per cycle, one cycle latency
    out_ready = 1'b1;
    drive(1'b1, 16'hA1B1, 2'b11); step();
    check("stream_lat1", out_data, 16'hA1B1);
    check("stream_lvl1", level, 1);
    drive(1'b1, 16'hA2B2, 2'b11); step();
    check("stream_lat2", out_data, 16'hA2B2);
    check("stream_lvl2", level, 1);
    drive(1'b1, 16'hA3B3, 2'b11); step();
    check("stream_lat3", out_data, 16'hA3B3);
    check("stream_lvl3", level, 1);
    drive(1'b0, 16'h0, 2'b00); step();
    check("stream_cnt", xfer_cnt, 3);
    check("stream_empty", level, 0);

    // Backpressure fills main and skid; third word refused
    out_ready = 1'b0;
    drive(1'b1, 16'h1122, 2'b11); step();
    drive(1'b1, 16'h3344, 2'b11); step();
    check("bp_level", level, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_hold", out_data, 16'h1122);
    drive(1'b1, 16'h5566, 2'b11); step();
    check("bp_refused_lvl", level, 2);
    check("bp_hold2", out_data, 16'h1122);
    drive(1'b0, 16'h0, 2'b00);
    out_ready = 1'b1;
    step();
    check("bp_pop_ready", in_ready, 1);
    check("bp_pop_data", out_data, 16'h3344);
    check("bp_pop_lvl", level, 1);
    step();
    check("bp_empty", level, 0);
    drain(4);

    // Mask 00 right after reset yields zeros
    do_reset();
    drive(1'b1, 16'hABCD, 2'b00); step();
    check("mask00_data", out_data, 16'h0000);
    // Channel 0 captured, channel 1 repeats its last accepted value
    drive(1'b1, 16'h1020, 2'b11); step();
    check("mask11_data", out_data, 16'h1020);
    drive(1'b1, 16'hFF30, 2'b01); step();
    check("mask01_data", out_data, 16'h1030);
    drive(1'b1, 16'hEE77, 2'b10); step();
    check("mask10_data", out_data, 16'hEE30);
    drive(1'b0, 16'h0, 2'b00);
    drain(4);

    // Simultaneous in/out in BUSY, counter wraps at 16
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, DW'($urandom), NUM_CH'($urandom));
      step();
      check("sim_level", level, 1);
    end
    drive(1'b0, 16'h0, 2'b00); step();
    check("wrap_cnt", xfer_cnt, 1);
    check("wrap_empty", level, 0);
    drain(4);

    // Reset while FULL discards everything
    out_ready = 1'b0;
    drive(1'b1, 16'h0102, 2'b11); step();
    drive(1'b1, 16'h0304, 2'b11); step();
    check("full_level", level, 2);
    rst = 1'b1;
    drive(1'b1, 16'h7777, 2'b11);
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0, 2'b00);
    check("rfull_level", level, 0);
    check("rfull_out_valid", out_valid, 0);
    check("rfull_in_ready", in_ready, 1);
    check("rfull_cnt", xfer_cnt, 0);
    check("rfull_data", out_data, 0);
    drive(1'b1, 16'h5A5A, 2'b11);
    out_ready = 1'b1;
    step();
    check("post_rst_word", out_data, 16'h5A5A);
    drive(1'b0, 16'h0, 2'b00);
    step();
    check("post_rst_empty", level, 0);
    check("post_rst_cnt", xfer_cnt, 1);
    drain(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
